// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU constants: register address width and hazard FSM states.
// Imported by hazard_ctrl and hazard_detect.
package hazard_ctrl_pkg;

  localparam int REG_W = 2;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL    = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Producer-match logic: flags a RAW hazard between ID sources and EX/MEM.
// Ports: ID sources/use bits, EX and MEM producers in; hazard out. Macro: FORWARDING_EN.
module hazard_detect #(
  parameter int REG_W = hazard_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             regwrite_ex,
  input  logic             memread_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             regwrite_mem,
  output logic             hazard
);

  logic ex_prod;
  logic mem_prod;
  logic rs_hit;
  logic rt_hit;

`ifdef FORWARDING_EN
  // Forwarding covers everything but a load still in EX.
  logic unused_mem;
  assign unused_mem = ^{rd_mem, regwrite_mem};
  assign ex_prod    = regwrite_ex & memread_ex;
  assign mem_prod   = 1'b0;
`else
  logic unused_mr;
  assign unused_mr = memread_ex;
  assign ex_prod   = regwrite_ex;
  assign mem_prod  = regwrite_mem;
`endif

  assign rs_hit = (ex_prod & (rs_id == rd_ex))
                | (mem_prod & (rs_id == rd_mem));
  assign rt_hit = (ex_prod & (rt_id == rd_ex))
                | (mem_prod & (rt_id == rd_mem));

  assign hazard = (rs_used_id & rs_hit)
                | (rt_used_id & rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard FSM: stalls, flushes and freezes with zero-latency outputs.
// Ports: ID/EX/MEM hazard inputs, mem_busy; enables, state_o, stall_cnt. Macro: FORWARDING_EN.
module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = hazard_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             regwrite_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             regwrite_mem,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt
);

  import hazard_ctrl_pkg::*;

  state_t state_q;
  state_t state_d;
  logic   hazard;
  logic   hz_eff;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_detect (
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .rs_used_id   (rs_used_id),
    .rt_used_id   (rt_used_id),
    .rd_ex        (rd_ex),
    .regwrite_ex  (regwrite_ex),
    .memread_ex   (memread_ex),
    .rd_mem       (rd_mem),
    .regwrite_mem (regwrite_mem),
    .hazard       (hazard)
  );

  // ID holds a flushed NOP right after a flush.
  assign hz_eff = hazard & (state_q != FLUSH);

  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    unique case (1'b1)
      mem_busy: begin
        state_d     = MEM_WAIT;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
      end
      (!mem_busy && branch_taken_ex): begin
        state_d     = FLUSH;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      (!mem_busy && !branch_taken_ex && hz_eff): begin
        state_d     = STALL;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Reset forces the idle pattern regardless of inputs.
    if (!rst_n) begin
      state_d     = RUN;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-002 Parameter REG_W, default 2, register-address width (R0..R3, R3 = SP).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 Inputs from the ID stage, each REG_W or 1 bit:
- rs_id, rt_id: ID-stage source addresses.
- rs_used_id, rt_used_id: the ID instruction reads rs_id / rt_id (includes implicit SP use).
REQ-006 Inputs from the EX stage:
- rd_ex (REG_W): destination address.
- regwrite_ex (1): EX instruction writes rd_ex.
- memread_ex (1): EX instruction is a load.
- branch_taken_ex (1): branch resolved taken in EX.
REQ-007 Inputs from the MEM stage: rd_mem (REG_W), regwrite_mem (1).
REQ-008 mem_busy  in  1  data memory not ready; the MEM access must be held.
REQ-009 Outputs, 1 bit each:
- pc_write: PC load enable.
- ifid_write: IF/ID register load enable.
- ifid_flush: clear IF/ID to NOP.
- idex_bubble: load a NOP into ID/EX (control bits zeroed).
- pipe_freeze: hold ID/EX, EX/MEM and MEM/WB.
REQ-010 state_o  out  2  current FSM state.
REQ-011 stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-012 The FSM SHALL have states RUN=00, STALL=01, FLUSH=10 and MEM_WAIT=11.
REQ-013 Control outputs SHALL be combinational from the current state and current inputs, so a hazard takes effect in the cycle it is detected (zero latency).
REQ-014 Priority, highest first: mem_busy, then branch_taken_ex, then data hazard.
REQ-015 mem_busy=1 in any state:
- pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0.
- Next state MEM_WAIT.
REQ-016 MEM_WAIT SHALL persist while mem_busy=1; on mem_busy=0 the cycle is evaluated as in RUN, including branch and hazard checks.
REQ-017 branch_taken_ex=1 with mem_busy=0:
- ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
- Next state FLUSH.
REQ-018 FLUSH SHALL last exactly one cycle:
- Data-hazard detection is suppressed, because ID holds a flushed NOP.
- Enables are 1 and bubble/flush are 0, unless mem_busy or a new branch_taken_ex applies.
- Next state RUN.
REQ-019 A data hazard exists when (rs_used_id and rs_id matches a producer) or (rt_used_id and rt_id matches a producer). Producers are defined in REQ-025/026.
REQ-020 On a data hazard with no higher-priority event:
- pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_freeze=0.
- Next state STALL.
REQ-021 STALL SHALL re-evaluate the hazard every cycle, stay in STALL while it persists, and return to RUN on the first hazard-free cycle with no other event.
REQ-022 With no event, outputs SHALL be pc_write=1, ifid_write=1 and all other control outputs 0; next state RUN.
REQ-023 stall_cnt SHALL increment by 1 on every cycle with pc_write=0 and SHALL saturate at all-ones without wrapping.
REQ-024 A branch arriving while in STALL SHALL take priority and flush; the stalled ID instruction is discarded.

Configuration
REQ-025 With FORWARDING_EN defined:
- The only producer is EX with regwrite_ex=1, memread_ex=1 and a matching rd_ex (load-use).
- This gives exactly one bubble; the forwarding unit covers all other RAW cases.
REQ-026 Without FORWARDING_EN:
- Producers are EX (regwrite_ex=1, matching rd_ex) and MEM (regwrite_mem=1, matching rd_mem).
- This gives 2 bubbles for an EX producer and 1 for a MEM producer; WB-to-ID is covered by write-first register file.

Reset
REQ-027 While rst_n=0:
- state SHALL be RUN and stall_cnt 0.
- Outputs SHALL be pc_write=1, ifid_write=1, all other control outputs 0.
REQ-028 Reset asserted mid-STALL, FLUSH or MEM_WAIT SHALL abort immediately and asynchronously; no pending bubble or flush survives.

Structure
REQ-029 A shared CPU package SHALL hold the state encoding constants (RUN, STALL, FLUSH, MEM_WAIT) and REG_W.
REQ-030 A single sub-module hazard_detect SHALL hold the combinational producer-match logic, including the FORWARDING_EN selection; the FSM, output decode and counter reside in hazard_ctrl.

Verification
REQ-031 FORWARDING_EN, load R1 in EX (memread_ex=1, rd_ex=01), ID reads rs_id=01 -> one cycle of pc_write=0, idex_bubble=1, state STALL; next cycle RUN; stall_cnt=1.
REQ-032 FORWARDING_EN, ALU write R2 in EX (memread_ex=0), ID reads R2 -> no stall, state RUN.
REQ-033 No FORWARDING_EN, ALU write R3 in EX, ID reads rt_id=11 -> 2 stall cycles (EX, then MEM match), then RUN; stall_cnt=2.
REQ-034 branch_taken_ex=1 coinciding with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_write=1, state FLUSH for 1 cycle, no STALL entry.
REQ-035 mem_busy=1 for 3 cycles during STALL -> pipe_freeze=1 and state MEM_WAIT for 3 cycles, then the hazard is re-evaluated; stall_cnt includes all frozen cycles.
REQ-036 Force stall_cnt to all-ones minus 1 and apply 3 stall cycles -> it holds at all-ones; rst_n low mid-STALL -> RUN, stall_cnt=0 asynchronously.
